mlp_layer_seq: RTL and testbench

- Time-multiplexed successor to the combinational binary MLP layer.
- Evaluates NUM_NEURONS binary (XNOR-popcount) neurons serially over a stored input vector, consuming CHUNK weight bits per cycle from an external weight ROM.
- Produces a thresholded output vector plus argmax class and winning count, so the block can serve as either a hidden or a final classification layer.
- Sits between the feature/flatten stage and the next layer; uses valid/ready handshakes on both sides.

---
 rtl/mlp_layer_seq.sv | 116 +++++++++++
 tb/tb_mlp_layer_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_layer_seq.sv
// Serial XNOR-popcount binary layer with thresholded output vector plus argmax class and count.
// Latency NUM_NEURONS*NUM_CHUNKS cycles from accept to out_valid; results held in DONE until out_ready.
module mlp_layer_seq #(
    parameter int INPUT_SIZE      = 784,
    parameter int NUM_NEURONS     = 10,
    parameter int CHUNK           = 16,
    parameter int THRESHOLD_WIDTH = $clog2(INPUT_SIZE + 1),
    parameter int NUM_CHUNKS      = (INPUT_SIZE + CHUNK - 1) / CHUNK,
    parameter int ADDR_WIDTH      = (NUM_NEURONS * NUM_CHUNKS > 1) ? $clog2(NUM_NEURONS * NUM_CHUNKS) : 1,
    localparam int NIDX_WIDTH     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INPUT_SIZE-1:0]      in_vector,
    output logic [ADDR_WIDTH-1:0]      w_addr,
    input  logic [CHUNK-1:0]           w_data,
    output logic [NIDX_WIDTH-1:0]      thr_idx,
    input  logic [THRESHOLD_WIDTH-1:0] thr_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_NEURONS-1:0]     out_vector,
    output logic [NIDX_WIDTH-1:0]      out_class,
    output logic [THRESHOLD_WIDTH-1:0] out_max_count
);

    localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int PW = NUM_CHUNKS * CHUNK;
    // Padding bits of the last chunk never contribute, whatever the ROM returns there.
    localparam logic [PW-1:0] VALID_MASK = {PW{1'b1}} >> (PW - INPUT_SIZE);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                     state, state_next;
    logic [PW-1:0]              in_reg;
    logic [NIDX_WIDTH-1:0]      n;
    logic [CW-1:0]              c;
    logic [THRESHOLD_WIDTH-1:0] acc, chunk_pop, count;
    logic [CHUNK-1:0]           in_chunk, mask_chunk, match;
    logic                       last_chunk, last_neuron;

    assign in_chunk    = in_reg[int'(c)*CHUNK +: CHUNK];
    assign mask_chunk  = VALID_MASK[int'(c)*CHUNK +: CHUNK];
    assign match       = ~(in_chunk ^ w_data) & mask_chunk;
    assign count       = acc + chunk_pop;
    assign last_chunk  = (c == CW'(NUM_CHUNKS - 1));
    assign last_neuron = (n == NIDX_WIDTH'(NUM_NEURONS - 1));

    assign w_addr    = ADDR_WIDTH'(int'(n) * NUM_CHUNKS + int'(c));
    assign thr_idx   = n;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        chunk_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_pop = chunk_pop + THRESHOLD_WIDTH'(match[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = COMPUTE;
            COMPUTE: if (last_chunk && last_neuron) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_reg        <= '0;
            n             <= '0;
            c             <= '0;
            acc           <= '0;
            out_vector    <= '0;
            out_class     <= '0;
            out_max_count <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                in_reg        <= PW'(in_vector);
                n             <= '0;
                c             <= '0;
                acc           <= '0;
                out_class     <= '0;
                out_max_count <= '0;
            end
        end else if (state == COMPUTE) begin
            if (last_chunk) begin
                out_vector[n] <= (count >= thr_data);
                // Strict compare keeps the lowest index on ties.
                if (count > out_max_count) begin
                    out_class     <= n;
                    out_max_count <= count;
                end
                acc <= '0;
                c   <= '0;
                n   <= n + 1'b1;
            end else begin
                acc <= count;
                c   <= c + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mlp_layer_seq.sv
// Bench for mlp_layer_seq: a small configuration for directed cases and the default one for random traffic.
module tb_mlp_layer_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, sel, in_valid, out_ready;
    logic [783:0] vin;
    int           total = 0;
    int           bad   = 0;

    typedef struct {
        logic [9:0] vec;
        logic [3:0] cls;
        logic [9:0] mx;
    } exp_t;
    exp_t exp_q[$];

    // Small instance: INPUT_SIZE=10, CHUNK=4, NUM_NEURONS=3
    logic        s_in_ready, s_out_valid;
    logic [3:0]  s_w_addr, s_w_data, s_thr_data, s_out_max_count;
    logic [1:0]  s_thr_idx, s_out_class;
    logic [2:0]  s_out_vector;
    logic [11:0] sw   [3];
    logic [3:0]  sthr [3];

    // Default instance
    logic         b_in_ready, b_out_valid;
    logic [8:0]   b_w_addr;
    logic [15:0]  b_w_data;
    logic [3:0]   b_thr_idx, b_out_class;
    logic [9:0]   b_thr_data, b_out_vector, b_out_max_count;
    logic [783:0] bw   [10];
    logic [9:0]   bthr [10];

    mlp_layer_seq #(.INPUT_SIZE(10), .NUM_NEURONS(3), .CHUNK(4)) u_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & ~sel), .in_ready(s_in_ready), .in_vector(vin[9:0]),
        .w_addr(s_w_addr), .w_data(s_w_data), .thr_idx(s_thr_idx), .thr_data(s_thr_data),
        .out_valid(s_out_valid), .out_ready(out_ready & ~sel),
        .out_vector(s_out_vector), .out_class(s_out_class), .out_max_count(s_out_max_count)
    );

    mlp_layer_seq u_big (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_vector(vin),
        .w_addr(b_w_addr), .w_data(b_w_data), .thr_idx(b_thr_idx), .thr_data(b_thr_data),
        .out_valid(b_out_valid), .out_ready(out_ready & sel),
        .out_vector(b_out_vector), .out_class(b_out_class), .out_max_count(b_out_max_count)
    );

    always_comb begin
        s_w_data   = '0;
        s_thr_data = '0;
        if (int'(s_w_addr) < 9) s_w_data = sw[int'(s_w_addr) / 3][(int'(s_w_addr) % 3) * 4 +: 4];
        if (int'(s_thr_idx) < 3) s_thr_data = sthr[int'(s_thr_idx)];
    end

    always_comb begin
        b_w_data   = '0;
        b_thr_data = '0;
        if (int'(b_w_addr) < 490) b_w_data = bw[int'(b_w_addr) / 49][(int'(b_w_addr) % 49) * 16 +: 16];
        if (int'(b_thr_idx) < 10) b_thr_data = bthr[int'(b_thr_idx)];
    end

    logic       v_in_ready, v_out_valid;
    logic [9:0] v_vec, v_max;
    logic [3:0] v_cls;
    assign v_in_ready  = sel ? b_in_ready  : s_in_ready;
    assign v_out_valid = sel ? b_out_valid : s_out_valid;
    assign v_vec       = sel ? b_out_vector    : {7'b0, s_out_vector};
    assign v_cls       = sel ? b_out_class     : {2'b0, s_out_class};
    assign v_max       = sel ? b_out_max_count : {6'b0, s_out_max_count};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic [9:0] vec, input logic [3:0] cls, input logic [9:0] mx);
        exp_t e;
        e.vec = vec;
        e.cls = cls;
        e.mx  = mx;
        exp_q.push_back(e);
    endtask

    task automatic start_txn(input logic [783:0] v);
        int w = 0;
        @(negedge clk);
        vin      = v;
        in_valid = 1'b1;
        while (!v_in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", 64'(v_in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic finish_txn(input int hold);
        int   lat = 0;
        exp_t e;
        while (lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
            if (v_out_valid) break;
        end
        check("latency", 64'(lat), 64'(sel ? 490 : 9));
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
            e.vec = '0; e.cls = '0; e.mx = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check("out_vector", 64'(v_vec), 64'(e.vec));
        check("out_class", 64'(v_cls), 64'(e.cls));
        check("out_max_count", 64'(v_max), 64'(e.mx));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = i[0];
            vin      = ~vin;
            @(posedge clk);
            #1;
            check("bp_hold", 64'({v_vec, v_cls, v_max}), 64'({e.vec, e.cls, e.mx}));
            check("bp_in_ready", 64'(v_in_ready), 64'd0);
            check("bp_out_valid", 64'(v_out_valid), 64'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("hs_out_valid", 64'(v_out_valid), 64'd0);
        check("hs_in_ready", 64'(v_in_ready), 64'd1);
    endtask

    initial begin
        logic [783:0] rv;
        logic [9:0]   mvec, mmax, cnt;
        logic [3:0]   mcls;

        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0; vin = '0;
        foreach (sw[i]) sw[i] = '0;
        foreach (sthr[i]) sthr[i] = '0;
        foreach (bw[i]) bw[i] = '0;
        foreach (bthr[i]) bthr[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(v_in_ready), 64'd1);
        check("rst_out_valid", 64'(v_out_valid), 64'd0);
        check("rst_out_vector", 64'(v_vec), 64'd0);
        check("rst_out_class", 64'(v_cls), 64'd0);
        check("rst_out_max", 64'(v_max), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Basic: counts 10, 0, 5 against thresholds 5, 1, 6
        sw[0] = 12'h3FF; sw[1] = 12'h000; sw[2] = 12'h01F;
        sthr[0] = 4'd5; sthr[1] = 4'd1; sthr[2] = 4'd6;
        push_exp(10'b001, 4'd0, 10'd10);
        start_txn(784'h3FF);
        finish_txn(0);

        // Padding bits set in the ROM must not count
        foreach (sw[i]) sw[i] = 12'hC00;
        foreach (sthr[i]) sthr[i] = 4'd10;
        push_exp(10'b111, 4'd0, 10'd10);
        start_txn(784'h000);
        finish_txn(0);

        // Tie 4,7,7 with zero thresholds, under 20 cycles of backpressure
        sw[0] = 12'h00F; sw[1] = 12'h07F; sw[2] = 12'h3F8;
        foreach (sthr[i]) sthr[i] = 4'd0;
        push_exp(10'b111, 4'd1, 10'd7);
        start_txn(784'h3FF);
        finish_txn(20);

        // Thresholds above INPUT_SIZE and equal to the count
        sthr[0] = 4'd11; sthr[1] = 4'd15; sthr[2] = 4'd7;
        push_exp(10'b100, 4'd1, 10'd7);
        start_txn(784'h3FF);
        finish_txn(0);

        // Reset mid-compute, then a clean transaction
        sw[0] = 12'h3FF; sw[1] = 12'h000; sw[2] = 12'h01F;
        sthr[0] = 4'd5; sthr[1] = 4'd1; sthr[2] = 4'd6;
        start_txn(784'h3FF);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(v_out_valid), 64'd0);
        check("midrst_in_ready", 64'(v_in_ready), 64'd1);
        check("midrst_out_max", 64'(v_max), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        push_exp(10'b001, 4'd0, 10'd10);
        start_txn(784'h3FF);
        finish_txn(0);

        // Default configuration against a bitwise reference
        sel = 1'b1;
        for (int t = 0; t < 50; t++) begin
            for (int i = 0; i < 784; i++) rv[i] = 1'($urandom);
            for (int n = 0; n < 10; n++) begin
                for (int i = 0; i < 784; i++) bw[n][i] = 1'($urandom);
                bthr[n] = 10'($urandom_range(360, 425));
            end
            if (t == 7) bthr[3] = 10'd0;
            if (t == 9) bthr[5] = 10'd1000;
            mvec = '0; mcls = '0; mmax = '0;
            for (int n = 0; n < 10; n++) begin
                cnt = '0;
                for (int i = 0; i < 784; i++) if (rv[i] == bw[n][i]) cnt++;
                mvec[n] = (cnt >= bthr[n]);
                if (n == 0 || cnt > mmax) begin
                    mmax = cnt;
                    mcls = 4'(n);
                end
            end
            push_exp(mvec, mcls, mmax);
            start_txn(rv);
            finish_txn(int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
